// File: rtl/mem_arb_pkg.sv
// Shared types and address helpers for the two-requester memory arbiter.
// The helpers cover word alignment and the per-size alignment rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2,
    BAD  = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_e;

  typedef enum logic {
    I = 1'b0,
    D = 1'b1
  } owner_e;

  // Lane k holds byte address+k; lane 0 occupies bits 7:0.
  typedef logic [3:0][7:0] byte_lanes_t;

  function automatic logic [31:0] word_base(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // An illegal size is reported here too, so one flag covers both checks.
  function automatic logic misaligned(input size_e size, input logic [1:0] offset);
    logic bad_s;
    case (size)
      BYTE:    bad_s = 1'b0;
      HALF:    bad_s = offset[0];
      WORD:    bad_s = (offset != 2'd0);
      default: bad_s = 1'b1;
    endcase
    return bad_s;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: merges store data into an old word for read-modify-write,
// and extracts and extends load data from a read word.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  byte_lanes_t lanes_s;
  byte_lanes_t old_lanes_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign old_lanes_s = old_word;
  assign byte_s      = old_lanes_s[offset];
  assign half_s      = {old_lanes_s[{offset[1], 1'b1}], old_lanes_s[{offset[1], 1'b0}]};

  // Store merge: replace only the addressed lanes.
  always_comb begin
    lanes_s = old_word;
    case (size_e'(size))
      BYTE: lanes_s[offset] = new_data[7:0];
      HALF: begin
        lanes_s[{offset[1], 1'b0}] = new_data[7:0];
        lanes_s[{offset[1], 1'b1}] = new_data[15:8];
      end
      WORD:    lanes_s = new_data;
      default: lanes_s = old_word;
    endcase
    merged_word = lanes_s;
  end

  // Load extract with sign or zero extension.
  always_comb begin
    case (size_e'(size))
      BYTE:    load_data = is_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      HALF:    load_data = is_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      WORD:    load_data = old_word;
      default: load_data = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-port memory,
// with alignment/range checks and read-modify-write for sub-word stores.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] MEM_START = 32'd0,
  parameter logic [31:0] MEM_TOP   = 32'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  output logic        i_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [1:0]  d_req_size,
  input  logic        d_req_unsigned,
  input  logic [31:0] d_req_wdata,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_rdata,
  output logic        d_resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] HI_C   = MEM_TOP - 32'd3;
  localparam logic [31:0] SPAN_C = HI_C - MEM_START;

  state_e      state_r, state_nxt_s;
  owner_e      last_r, owner_r;
  logic [31:0] addr_r, wdata_r;
  size_e       size_r;
  logic        we_r, uns_r;

  logic        idle_s, grant_i_s, grant_d_s, accept_s;
  logic [31:0] acc_addr_s, acc_base_s;
  size_e       acc_size_s;
  logic        acc_we_s, acc_uns_s, acc_err_s;

  logic [31:0] merged_s, load_s;

  logic        i_resp_valid_r, i_resp_valid_nxt_s;
  logic [31:0] i_resp_data_r, i_resp_data_nxt_s;
  logic        i_resp_err_r, i_resp_err_nxt_s;
  logic        d_resp_valid_r, d_resp_valid_nxt_s;
  logic [31:0] d_resp_rdata_r, d_resp_rdata_nxt_s;
  logic        d_resp_err_r, d_resp_err_nxt_s;
  logic [31:0] mem_addr_r, mem_addr_nxt_s;
  logic [31:0] mem_wdata_r, mem_wdata_nxt_s;
  logic        mem_we_r, mem_we_nxt_s;

  // Ties go to whoever was not served last; nothing is granted while in reset.
  assign idle_s      = (state_r == IDLE) && !rst;
  assign grant_i_s   = idle_s && i_req_valid && (!d_req_valid || (last_r == D));
  assign grant_d_s   = idle_s && d_req_valid && !grant_i_s;
  assign accept_s    = grant_i_s || grant_d_s;
  assign i_req_ready = grant_i_s;
  assign d_req_ready = grant_d_s;

  // Select the granted request's fields and run the acceptance checks.
  always_comb begin
    if (grant_i_s) begin
      acc_addr_s = i_req_addr;
      acc_size_s = WORD;
      acc_we_s   = 1'b0;
      acc_uns_s  = 1'b0;
    end else begin
      acc_addr_s = d_req_addr;
      acc_size_s = size_e'(d_req_size);
      acc_we_s   = d_req_we;
      acc_uns_s  = d_req_unsigned;
    end
    acc_base_s = word_base(acc_addr_s);
    // Offsetting by MEM_START turns the two-sided range test into one unsigned compare.
    acc_err_s  = misaligned(acc_size_s, acc_addr_s[1:0]) ||
                 ((acc_base_s - MEM_START) > SPAN_C);
  end

  mem_lane_align u_align (
    .old_word    (mem_rdata),
    .new_data    (wdata_r),
    .size        (size_r),
    .offset      (addr_r[1:0]),
    .is_unsigned (uns_r),
    .merged_word (merged_s),
    .load_data   (load_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latch and fairness flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r  <= D;
      owner_r <= I;
      addr_r  <= 32'h00000000;
      wdata_r <= 32'h00000000;
      size_r  <= BYTE;
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
    end else if (accept_s) begin
      last_r  <= grant_i_s ? I : D;
      owner_r <= grant_i_s ? I : D;
      addr_r  <= acc_addr_s;
      wdata_r <= d_req_wdata;
      size_r  <= acc_size_s;
      we_r    <= acc_we_s;
      uns_r   <= acc_uns_s;
    end
  end

  // Next state plus the values every output register takes on entry to that state.
  always_comb begin
    state_nxt_s        = state_r;
    i_resp_valid_nxt_s = 1'b0;
    i_resp_data_nxt_s  = 32'h00000000;
    i_resp_err_nxt_s   = 1'b0;
    d_resp_valid_nxt_s = 1'b0;
    d_resp_rdata_nxt_s = 32'h00000000;
    d_resp_err_nxt_s   = 1'b0;
    mem_addr_nxt_s     = 32'h00000000;
    mem_wdata_nxt_s    = 32'h00000000;
    mem_we_nxt_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_nxt_s = IDLE;
        end else if (acc_err_s) begin
          state_nxt_s        = ERR;
          i_resp_valid_nxt_s = grant_i_s;
          i_resp_err_nxt_s   = grant_i_s;
          d_resp_valid_nxt_s = grant_d_s;
          d_resp_err_nxt_s   = grant_d_s;
        end else if (acc_we_s && (acc_size_s == WORD)) begin
          state_nxt_s     = WR;
          mem_we_nxt_s    = 1'b1;
          mem_addr_nxt_s  = acc_base_s;
          mem_wdata_nxt_s = d_req_wdata;
        end else begin
          state_nxt_s    = RD;
          mem_addr_nxt_s = acc_base_s;
        end
      end
      RD: begin
        if (we_r) begin
          state_nxt_s     = WR;
          mem_we_nxt_s    = 1'b1;
          mem_addr_nxt_s  = word_base(addr_r);
          mem_wdata_nxt_s = merged_s;
        end else if (owner_r == I) begin
          state_nxt_s        = RESP;
          i_resp_valid_nxt_s = 1'b1;
          i_resp_data_nxt_s  = mem_rdata;
        end else begin
          state_nxt_s        = RESP;
          d_resp_valid_nxt_s = 1'b1;
          d_resp_rdata_nxt_s = load_s;
        end
      end
      WR: begin
        state_nxt_s        = RESP;
        d_resp_valid_nxt_s = 1'b1;
      end
      RESP:    state_nxt_s = IDLE;
      ERR:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output registers; reset clears them so an in-flight access is dropped silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_resp_valid_r <= 1'b0;
      i_resp_data_r  <= 32'h00000000;
      i_resp_err_r   <= 1'b0;
      d_resp_valid_r <= 1'b0;
      d_resp_rdata_r <= 32'h00000000;
      d_resp_err_r   <= 1'b0;
      mem_addr_r     <= 32'h00000000;
      mem_wdata_r    <= 32'h00000000;
      mem_we_r       <= 1'b0;
    end else begin
      i_resp_valid_r <= i_resp_valid_nxt_s;
      i_resp_data_r  <= i_resp_data_nxt_s;
      i_resp_err_r   <= i_resp_err_nxt_s;
      d_resp_valid_r <= d_resp_valid_nxt_s;
      d_resp_rdata_r <= d_resp_rdata_nxt_s;
      d_resp_err_r   <= d_resp_err_nxt_s;
      mem_addr_r     <= mem_addr_nxt_s;
      mem_wdata_r    <= mem_wdata_nxt_s;
      mem_we_r       <= mem_we_nxt_s;
    end
  end

  assign i_resp_valid = i_resp_valid_r;
  assign i_resp_data  = i_resp_data_r;
  assign i_resp_err   = i_resp_err_r;
  assign d_resp_valid = d_resp_valid_r;
  assign d_resp_rdata = d_resp_rdata_r;
  assign d_resp_err   = d_resp_err_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign mem_we       = mem_we_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses, writes
// and grants; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0, i_req_ready;
  logic [31:0] i_req_addr = 32'h0;
  logic        i_resp_valid, i_resp_err;
  logic [31:0] i_resp_data;
  logic        d_req_valid = 1'b0, d_req_ready;
  logic [31:0] d_req_addr = 32'h0, d_req_wdata = 32'h0;
  logic        d_req_we = 1'b0, d_req_unsigned = 1'b0;
  logic [1:0]  d_req_size = 2'd0;
  logic        d_resp_valid, d_resp_err;
  logic [31:0] d_resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_size(d_req_size), .d_req_unsigned(d_req_unsigned),
    .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Memory model: combinational read, write on the edge that ends the WR cycle.
  logic [31:0] mem_w [0:16383] = '{4: 32'h12345678, default: 32'h0};
  assign mem_rdata = mem_w[mem_addr[15:2]];
  always @(posedge clk) if (mem_we) mem_w[mem_addr[15:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_d; logic [31:0] data; bit err; int cyc; string name; } resp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; string name; } wr_t;
  typedef struct { bit is_d; int cyc; } gnt_t;
  resp_t exp_q[$];
  wr_t   wr_q[$];
  gnt_t  gnt_q[$];

  int checks = 0, failures = 0, timeouts = 0;
  bit idle_chk = 1'b0, grant_track = 1'b0, final_chk = 1'b0;

  // Monitor: every comparison of the bench happens here.
  always @(negedge clk) begin
    resp_t e; wr_t w; gnt_t g;
    logic [31:0] got_data; logic got_err;
    if (idle_chk) begin
      checks++;
      if ({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, i_resp_err, d_resp_err, mem_we} != 7'b0 ||
          i_resp_data != 32'h0 || d_resp_rdata != 32'h0 || mem_addr != 32'h0 || mem_wdata != 32'h0) begin
        failures++;
        $display("FAIL idle_outputs cyc=%0d: rdy=%b%b rv=%b%b err=%b%b we=%b idata=%h drdata=%h addr=%h wdata=%h, expected all zero",
                 cyc, i_req_ready, d_req_ready, i_resp_valid, d_resp_valid, i_resp_err, d_resp_err,
                 mem_we, i_resp_data, d_resp_rdata, mem_addr, mem_wdata);
      end
    end
    if (i_resp_valid || d_resp_valid) begin
      checks++;
      got_data = d_resp_valid ? d_resp_rdata : i_resp_data;
      got_err  = d_resp_valid ? d_resp_err : i_resp_err;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp cyc=%0d: ivalid=%b dvalid=%b data=%h, expected no response",
                 cyc, i_resp_valid, d_resp_valid, got_data);
      end else begin
        e = exp_q.pop_front();
        if ((i_resp_valid && d_resp_valid) || (d_resp_valid != e.is_d) ||
            got_data != e.data || got_err != e.err || cyc != e.cyc) begin
          failures++;
          $display("FAIL %s: got d=%b i=%b data=%h err=%b cyc=%0d, expected d=%b data=%h err=%b cyc=%0d",
                   e.name, d_resp_valid, i_resp_valid, got_data, got_err, cyc, e.is_d, e.data, e.err, e.cyc);
        end
      end
    end
    if (mem_we) begin
      checks++;
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write cyc=%0d: addr=%h data=%h, expected no write", cyc, mem_addr, mem_wdata);
      end else begin
        w = wr_q.pop_front();
        if (mem_addr != w.addr || mem_wdata != w.data || cyc != w.cyc) begin
          failures++;
          $display("FAIL %s_write: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d",
                   w.name, mem_addr, mem_wdata, cyc, w.addr, w.data, w.cyc);
        end
      end
    end
    if (grant_track && (i_req_ready || d_req_ready)) begin
      checks++;
      if (gnt_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_grant cyc=%0d: i=%b d=%b", cyc, i_req_ready, d_req_ready);
      end else begin
        g = gnt_q.pop_front();
        if ((i_req_ready && d_req_ready) || d_req_ready != g.is_d || cyc != g.cyc) begin
          failures++;
          $display("FAIL grant_order: got i=%b d=%b cyc=%0d, expected d=%b cyc=%0d",
                   i_req_ready, d_req_ready, cyc, g.is_d, g.cyc);
        end
      end
    end
    if (final_chk) begin
      checks++;
      if (exp_q.size() != 0 || wr_q.size() != 0 || gnt_q.size() != 0 || timeouts != 0) begin
        failures++;
        $display("FAIL drain: pending resp=%0d write=%0d grant=%0d timeouts=%0d, expected all 0",
                 exp_q.size(), wr_q.size(), gnt_q.size(), timeouts);
      end
    end
  end

  task automatic i_op(input logic [31:0] addr, input bit exp_err, input logic [31:0] exp_data,
                      input string name);
    bit got = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = addr;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = i_req_ready;
    end
    if (!got) begin
      timeouts++;
      $display("timeout waiting for i_req_ready (%s)", name);
    end else begin
      exp_q.push_back('{1'b0, exp_err ? 32'h0 : exp_data, exp_err, cyc + (exp_err ? 1 : 2), name});
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  task automatic d_op(input logic [31:0] addr, input bit we, input logic [1:0] size, input bit uns,
                      input logic [31:0] wdata, input bit exp_err, input logic [31:0] exp_data,
                      input bit track, input string name);
    bit got = 1'b0;
    int lat;
    d_req_valid = 1'b1; d_req_addr = addr; d_req_we = we;
    d_req_size = size; d_req_unsigned = uns; d_req_wdata = wdata;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = d_req_ready;
    end
    if (!got) begin
      timeouts++;
      $display("timeout waiting for d_req_ready (%s)", name);
    end else if (track) begin
      lat = exp_err ? 1 : ((we && size != 2'd2) ? 3 : 2);
      // For stores exp_data is the memory word after the write; the response carries 0.
      if (we && !exp_err)
        wr_q.push_back('{{addr[31:2], 2'b00}, exp_data, cyc + lat - 1, name});
      exp_q.push_back('{1'b1, (we || exp_err) ? 32'h0 : exp_data, exp_err, cyc + lat, name});
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0;
  endtask

  initial begin
    int rel;
    // Both requesters valid from reset: I first, then strict alternation.
    fork
      begin
        @(posedge clk); #1 idle_chk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        idle_chk = 1'b0;
        rst = 1'b0;
        rel = cyc;
        gnt_q.push_back('{1'b0, rel});
        gnt_q.push_back('{1'b1, rel + 3});
        gnt_q.push_back('{1'b0, rel + 6});
        gnt_q.push_back('{1'b1, rel + 9});
        grant_track = 1'b1;
      end
      begin
        i_op(32'h10, 1'b0, 32'h12345678, "contend_fetch0");
        i_op(32'h10, 1'b0, 32'h12345678, "contend_fetch1");
      end
      begin
        d_op(32'h0C, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "contend_load0");
        d_op(32'h0C, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, "contend_load1");
      end
    join
    grant_track = 1'b0;

    // Word store/load, then byte and half read-modify-write with extension.
    d_op(32'h0C, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b1, "word_store");
    d_op(32'h0C, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, "word_load");
    d_op(32'h0D, 1'b1, 2'd0, 1'b0, 32'h12345680, 1'b0, 32'hDEAD80EF, 1'b1, "byte_store");
    d_op(32'h0D, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1, "byte_load_s");
    d_op(32'h0D, 1'b0, 2'd0, 1'b1, 32'h0,        1'b0, 32'h00000080, 1'b1, "byte_load_u");
    d_op(32'h0E, 1'b0, 2'd1, 1'b0, 32'h0,        1'b0, 32'hFFFFDEAD, 1'b1, "half_load_s");
    d_op(32'h0C, 1'b0, 2'd1, 1'b1, 32'h0,        1'b0, 32'h000080EF, 1'b1, "half_load_u");
    d_op(32'h0E, 1'b1, 2'd1, 1'b0, 32'hABCD1234, 1'b0, 32'h123480EF, 1'b1, "half_store");
    d_op(32'h0C, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0, 32'h123480EF, 1'b1, "word_load_rmw");

    // Error cases: no memory access, response one cycle after acceptance.
    d_op(32'h03,    1'b0, 2'd1, 1'b0, 32'h0,        1'b1, 32'h0, 1'b1, "err_half_mis");
    d_op(32'h0E,    1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 32'h0, 1'b1, "err_word_mis");
    d_op(32'h0C,    1'b0, 2'd3, 1'b0, 32'h0,        1'b1, 32'h0, 1'b1, "err_size3");
    d_op(32'h0E,    1'b1, 2'd2, 1'b0, 32'h55555555, 1'b1, 32'h0, 1'b1, "err_store_mis");
    d_op(32'h10000, 1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 32'h0, 1'b1, "err_range");
    d_op(32'hFFFF,  1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 32'h0, 1'b1, "top_byte_load");
    i_op(32'hFFFE, 1'b1, 32'h0,        "fetch_top_mis");
    i_op(32'h10,   1'b0, 32'h12345678, "fetch_0x10");
    i_op(32'hFFFC, 1'b0, 32'h0,        "fetch_top_word");

    // Reset during the RD cycle of a byte store: no write, no response.
    d_op(32'h0D, 1'b1, 2'd0, 1'b0, 32'h00000055, 1'b0, 32'h0, 1'b0, "rst_store");
    rst = 1'b1;
    @(posedge clk); #1 idle_chk = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 idle_chk = 1'b0;
    d_op(32'h0C, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 32'h123480EF, 1'b1, "load_after_rst");

    repeat (6) @(posedge clk);
    #1 final_chk = 1'b1;
    @(negedge clk);
    #1 final_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
